// File: rtl/ul4_pkg.sv
// ul4_pkg: shared encodings and types for the ul4 sequenced logic unit.
//   DATA_W / OP_W  : operand and op-select widths
//   OP_*           : logic-unit operation encodings
//   ST_*           : ul4_seq FSM state encodings
//   ul4_opnd_t     : latched operand bundle
package ul4_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned ST_W   = 2;

    localparam logic [OP_W-1:0] OP_AND = 2'b00;
    localparam logic [OP_W-1:0] OP_OR  = 2'b01;
    localparam logic [OP_W-1:0] OP_XOR = 2'b10;
    localparam logic [OP_W-1:0] OP_NOT = 2'b11;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_EXEC = 2'd1;
    localparam logic [ST_W-1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } ul4_opnd_t;

endpackage

// File: rtl/ul4_seq_if.sv
// ul4_seq_if: request/result handshake bundle for ul4_seq.
//   req_valid/req_ready, req_a, req_b, req_op (+ req_chain with UL4_CHAIN_EN)
//   res_valid/res_ready, res_data, res_zero
//   master: the requester / result consumer; slave: ul4_seq.
interface ul4_seq_if;
    import ul4_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [OP_W-1:0]   req_op;
`ifdef UL4_CHAIN_EN
    logic              req_chain;
`endif
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_zero;

    modport master (
`ifdef UL4_CHAIN_EN
        output req_chain,
`endif
        output req_valid, req_a, req_b, req_op, res_ready,
        input  req_ready, res_valid, res_data, res_zero
    );

    modport slave (
`ifdef UL4_CHAIN_EN
        input  req_chain,
`endif
        input  req_valid, req_a, req_b, req_op, res_ready,
        output req_ready, res_valid, res_data, res_zero
    );

endinterface

// File: rtl/ul4.sv
// ul4: 4-bit combinational logic unit.
//   a, b : operands
//   op   : OP_AND / OP_OR / OP_XOR / OP_NOT (NOT ignores b)
//   y_c  : result
module ul4
    import ul4_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] y_c
);

    always_comb begin
        y_c = '0;
        case (op)
            OP_AND: y_c = a & b;
            OP_OR:  y_c = a | b;
            OP_XOR: y_c = a ^ b;
            OP_NOT: y_c = ~a;
        endcase
    end

endmodule

// File: rtl/ul4_seq.sv
// ul4_seq: sequences one ul4 operation per request through IDLE -> EXEC -> RESP.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : ul4_seq_if.slave request/result handshake
//   ops_done   : saturating count of consumed results (OPS_W bits)
// Optional feature: define UL4_CHAIN_EN to add req_chain, which substitutes the
// current res_data for operand A at acceptance.
module ul4_seq
    import ul4_pkg::*;
#(
    parameter int unsigned OPS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    ul4_seq_if.slave         bus,
    output logic [OPS_W-1:0] ops_done
);

    logic [ST_W-1:0]   state_q, state_d;
    ul4_opnd_t         opnd_q, opnd_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_zero_q, res_zero_d;
    logic              res_valid_q, res_valid_d;
    logic              rdy_q, rdy_d;
    logic [OPS_W-1:0]  ops_q, ops_d;
    logic [DATA_W-1:0] alu_y;

    // Single logic unit, fed only from the latched operands.
    ul4 u_ul4 (
        .a   (opnd_q.a),
        .b   (opnd_q.b),
        .op  (opnd_q.op),
        .y_c (alu_y)
    );

    // Next-state, operand capture, result capture and counter update.
    always_comb begin
        state_d    = state_q;
        opnd_d     = opnd_q;
        res_data_d = res_data_q;
        res_zero_d = res_zero_q;
        ops_d      = ops_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    opnd_d.a  = bus.req_a;
`ifdef UL4_CHAIN_EN
                    if (bus.req_chain) begin
                        opnd_d.a = res_data_q;
                    end
`endif
                    opnd_d.b  = bus.req_b;
                    opnd_d.op = bus.req_op;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_data_d = alu_y;
                res_zero_d = (alu_y == '0);
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                    if (ops_q != '1) begin
                        ops_d = ops_q + OPS_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags are registered from the state being entered.
        res_valid_d = (state_d == ST_RESP);
        rdy_d       = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            opnd_q      <= '0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b1;
            res_valid_q <= 1'b0;
            rdy_q       <= 1'b1;
            ops_q       <= '0;
        end else begin
            state_q     <= state_d;
            opnd_q      <= opnd_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            res_valid_q <= res_valid_d;
            rdy_q       <= rdy_d;
            ops_q       <= ops_d;
        end
    end

    // Ready is masked by rst_n so it drops as soon as reset is asserted.
    assign bus.req_ready = rdy_q & rst_n;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_zero  = res_zero_q;
    assign ops_done      = ops_q;

endmodule
